alu_seq_unit: RTL and testbench

//   Width-parametrised successor to the 4-bit-opcode accumulator ALU. Holds A/B operand

---
 rtl/alu_seq_unit.sv | 191 +++++++++++++++++++
 tb/tb_alu_seq_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
// ---------------------------------------------------------------------------
// alu_seq_unit
//   Accumulator-style ALU with A/B operand registers. Operands are loaded from
//   the immediate bus (data_in) or the RAM read port (ram_in). ADD, SUB, AND,
//   OR, XOR, SHL and SHR complete in one cycle. MUL is an unsigned shift-add
//   multiply that takes WIDTH cycles. The block reports flags {V,N,C,Z}.
//
// Ports
//   clock    in   1      rising-edge clock
//   reset    in   1      asynchronous, active-high reset
//   data_in  in   WIDTH  immediate operand bus
//   ram_in   in   WIDTH  RAM read-data operand bus
//   inst     in   4      opcode
//   rtn      out  WIDTH  registered result
//   flags    out  4      {V,N,C,Z}, registered
//   busy     out  1      high while a MUL is in progress (FSM state == MUL)
//   done     out  1      one-cycle pulse on the edge rtn is updated
//
// Handshake: inst is treated as a command that is valid on every rising edge.
//   busy is the inverse of ready. A command is taken only on an edge where
//   busy is low. Commands presented while busy is high are dropped. There is
//   no retry and no back-pressure. A new command is accepted on every cycle
//   while the unit is idle.
// ---------------------------------------------------------------------------
module alu_seq_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] ram_in,
    input  logic [3:0]       inst,
    output logic [WIDTH-1:0] rtn,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_LDA_D = 4'h3;
    localparam logic [3:0] OP_LDB_D = 4'h4;
    localparam logic [3:0] OP_LDA_R = 4'h5;
    localparam logic [3:0] OP_LDB_R = 4'h6;
    localparam logic [3:0] OP_ADD   = 4'h7;
    localparam logic [3:0] OP_SUB   = 4'h8;
    localparam logic [3:0] OP_AND   = 4'h9;
    localparam logic [3:0] OP_OR    = 4'hA;
    localparam logic [3:0] OP_XOR   = 4'hB;
    localparam logic [3:0] OP_SHL   = 4'hC;
    localparam logic [3:0] OP_SHR   = 4'hD;
    localparam logic [3:0] OP_MUL   = 4'hE;

    typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   mcand, mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      count;
    logic               mul_last;

    // Single-cycle ALU result for the opcode currently on inst
    logic [WIDTH:0]     sum, diff;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v, alu_is_res;

    // Multiply step
    logic [2*WIDTH-1:0] mul_addend, acc_nxt;
    logic               mul_hi;

    assign mul_last = (count == CW'(WIDTH - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (inst == OP_MUL) state_nxt = ST_MUL;
            ST_MUL:  if (mul_last)       state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state == ST_MUL);
    end

    // ---------------- single-cycle ALU ----------------
    always_comb begin
        sum        = {1'b0, a_q} + {1'b0, b_q};
        diff       = {1'b0, a_q} - {1'b0, b_q};
        alu_res    = '0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        alu_is_res = 1'b1;
        case (inst)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                // Like-signed operands producing an opposite-signed sum
                alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                          (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];   // borrow out == (A < B) unsigned
                alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                          (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_SHL: begin
                alu_res = {a_q[WIDTH-2:0], 1'b0};
                alu_c   = a_q[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, a_q[WIDTH-1:1]};
                alu_c   = a_q[0];
            end
            default: alu_is_res = 1'b0;
        endcase
    end

    // ---------------- multiply step ----------------
    always_comb begin
        mul_addend = '0;
        if (mplier[count]) mul_addend = {{WIDTH{1'b0}}, mcand} << count;
        acc_nxt = acc + mul_addend;
        mul_hi  = |acc_nxt[2*WIDTH-1:WIDTH];
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            rtn    <= '0;
            flags  <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                case (inst)
                    OP_LDA_D: a_q <= data_in;
                    OP_LDB_D: b_q <= data_in;
                    OP_LDA_R: a_q <= ram_in;
                    OP_LDB_R: b_q <= ram_in;
                    OP_MUL: begin
                        // Snapshot operands so the multiply is independent of A/B
                        mcand  <= a_q;
                        mplier <= b_q;
                        acc    <= '0;
                        count  <= '0;
                    end
                    default: begin
                        if (alu_is_res) begin
                            rtn   <= alu_res;
                            flags <= {alu_v, alu_res[WIDTH-1], alu_c,
                                      (alu_res == '0)};
                            done  <= 1'b1;
                        end
                    end
                endcase
            end else begin
                acc   <= acc_nxt;
                count <= count + 1'b1;
                if (mul_last) begin
                    // Any bit above the low word counts as both carry and overflow
                    rtn   <= acc_nxt[WIDTH-1:0];
                    flags <= {mul_hi, acc_nxt[WIDTH-1], mul_hi,
                              (acc_nxt[WIDTH-1:0] == '0)};
                    done  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_unit
//   Directed scenarios followed by random opcode/data stimulus. Expected
//   values come from a behavioural model built on integer arithmetic and a
//   countdown for the multi-cycle multiply.
// ---------------------------------------------------------------------------
module tb_alu_seq_unit;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] data_in, ram_in;
    logic [3:0]   inst;
    logic [W-1:0] rtn;
    logic [3:0]   flags;
    logic         busy, done;

    always #5 clock = ~clock;

    alu_seq_unit #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset   (reset),
        .data_in (data_in),
        .ram_in  (ram_in),
        .inst    (inst),
        .rtn     (rtn),
        .flags   (flags),
        .busy    (busy),
        .done    (done)
    );

    // ---------------- scoreboard ----------------
    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] m_a, m_b, m_rtn, m_mcand, m_mplier;
    logic [3:0]   m_flags;
    logic         m_done;
    int           m_mul_left;

    task automatic model_reset();
        m_a = '0; m_b = '0; m_rtn = '0; m_flags = '0; m_done = 1'b0;
        m_mcand = '0; m_mplier = '0; m_mul_left = 0;
    endtask

    task automatic model_result(input longint val, input logic c, input logic v);
        m_rtn   = W'(val);
        m_flags = {v, m_rtn[W-1], c, (m_rtn == 0)};
        m_done  = 1'b1;
    endtask

    task automatic model_step(input logic [3:0] op, input logic [W-1:0] d,
                              input logic [W-1:0] r);
        longint u, s;
        logic [2*W-1:0] prod;
        logic hi;
        m_done = 1'b0;
        if (m_mul_left > 0) begin
            m_mul_left--;
            if (m_mul_left == 0) begin
                prod = {{W{1'b0}}, m_mcand} * {{W{1'b0}}, m_mplier};
                hi   = (prod >> W) != 0;
                model_result(longint'(prod), hi, hi);
            end
        end else begin
            case (op)
                4'h3: m_a = d;
                4'h4: m_b = d;
                4'h5: m_a = r;
                4'h6: m_b = r;
                4'h7: begin
                    u = longint'(m_a) + longint'(m_b);
                    s = longint'($signed(m_a)) + longint'($signed(m_b));
                    model_result(u, u >= (64'sd1 << W),
                                 s > ((64'sd1 << (W-1)) - 1) || s < -(64'sd1 << (W-1)));
                end
                4'h8: begin
                    u = longint'(m_a) - longint'(m_b);
                    s = longint'($signed(m_a)) - longint'($signed(m_b));
                    model_result(u, m_a < m_b,
                                 s > ((64'sd1 << (W-1)) - 1) || s < -(64'sd1 << (W-1)));
                end
                4'h9: model_result(longint'(m_a & m_b), 1'b0, 1'b0);
                4'hA: model_result(longint'(m_a | m_b), 1'b0, 1'b0);
                4'hB: model_result(longint'(m_a ^ m_b), 1'b0, 1'b0);
                4'hC: model_result(longint'(m_a) * 2, m_a[W-1], 1'b0);
                4'hD: model_result(longint'(m_a) / 2, m_a[0], 1'b0);
                4'hE: begin
                    m_mcand    = m_a;
                    m_mplier   = m_b;
                    m_mul_left = W;
                end
                default: ;
            endcase
        end
        if (m_done) exp_q.push_back(m_rtn);
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge: drive, let one rising edge pass, then compare.
    task automatic cyc(input logic [3:0] op, input logic [W-1:0] d,
                       input logic [W-1:0] r);
        inst = op; data_in = d; ram_in = r;
        @(posedge clock);
        model_step(op, d, r);
        @(negedge clock);
        check("rtn",   32'(rtn),   32'(m_rtn));
        check("flags", 32'(flags), 32'(m_flags));
        check("busy",  32'(busy),  32'(m_mul_left > 0));
        check("done",  32'(done),  32'(m_done));
        if (done) begin
            if (exp_q.size() == 0) check("sb_spurious_done", 32'(1), 32'(0));
            else                   check("sb_rtn", 32'(rtn), 32'(exp_q.pop_front()));
        end
    endtask

    // Start a MUL and run until busy drops; optionally poke loads/ADD while busy.
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit interfere);
        int nb;
        cyc(4'h3, a, 0);
        cyc(4'h6, 0, b);
        cyc(4'hE, 0, 0);
        nb = 0;
        for (int i = 0; i < 5 * W && busy; i++) begin
            nb++;
            if (interfere && i == 0)      cyc(4'h3, 8'h55, 0);
            else if (interfere && i == 1) cyc(4'h7, 0, 0);
            else if (interfere)           cyc(4'h5, 0, 8'hAA);
            else                          cyc(4'h0, 0, 0);
        end
        check("mul_busy_cycles", 32'(nb), 32'(W));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; inst = '0; data_in = '0; ram_in = '0;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("reset_rtn",   32'(rtn),   32'(0));
        check("reset_flags", 32'(flags), 32'(0));
        check("reset_busy",  32'(busy),  32'(0));
        check("reset_done",  32'(done),  32'(0));

        // 1: signed overflow on ADD
        cyc(4'h3, 8'h7F, 0);
        cyc(4'h6, 0, 8'h01);
        cyc(4'h7, 0, 0);
        check("t1_rtn",   32'(rtn),   32'h80);
        check("t1_flags", 32'(flags), 32'b1100);
        cyc(4'h0, 0, 0);
        check("t1_done_drop", 32'(done), 32'(0));

        // 2: SUB to zero, then with borrow
        cyc(4'h3, 8'h05, 0);
        cyc(4'h4, 8'h05, 0);
        cyc(4'h8, 0, 0);
        check("t2a_flags", 32'(flags), 32'b0001);
        cyc(4'h3, 8'h03, 0);
        cyc(4'h8, 0, 0);
        check("t2b_rtn",   32'(rtn),   32'hFE);
        check("t2b_flags", 32'(flags), 32'b0110);

        // 3: multiplies
        run_mul(8'h0C, 8'h0B, 1'b0);
        check("t3a_rtn",   32'(rtn),   32'h84);
        check("t3a_flags", 32'(flags), 32'b0100);
        run_mul(8'h10, 8'h10, 1'b0);
        check("t3b_rtn",   32'(rtn),   32'h00);
        check("t3b_flags", 32'(flags), 32'b1011);

        // 4: loads and ADD during MUL are dropped
        run_mul(8'h22, 8'h03, 1'b1);
        check("t4_mul_rtn", 32'(rtn), 32'h66);
        cyc(4'h7, 0, 0);
        check("t4_add_old_a", 32'(rtn), 32'h25);

        // Back-to-back single-cycle ops
        cyc(4'h9, 0, 0);
        cyc(4'hA, 0, 0);
        cyc(4'hB, 0, 0);

        // 5: reset during MUL cycle 4
        cyc(4'h3, 8'hFF, 0);
        cyc(4'h4, 8'hFF, 0);
        cyc(4'hE, 0, 0);
        repeat (3) cyc(4'h0, 0, 0);
        reset = 1'b1;
        #1;
        check("t5_rtn",   32'(rtn),   32'(0));
        check("t5_flags", 32'(flags), 32'(0));
        check("t5_busy",  32'(busy),  32'(0));
        check("t5_done",  32'(done),  32'(0));
        model_reset();
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        cyc(4'h7, 0, 0);
        check("t5_post_rtn",   32'(rtn),   32'(0));
        check("t5_post_flags", 32'(flags), 32'b0001);

        // 6: shifts and XOR
        cyc(4'h3, 8'h81, 0);
        cyc(4'hC, 0, 0);
        check("t6_shl_rtn",   32'(rtn),   32'h02);
        check("t6_shl_flags", 32'(flags), 32'b0010);
        cyc(4'h3, 8'h01, 0);
        cyc(4'hD, 0, 0);
        check("t6_shr_flags", 32'(flags), 32'b0011);
        cyc(4'h4, 8'h01, 0);
        cyc(4'hB, 0, 0);
        check("t6_xor_flags", 32'(flags), 32'b0001);

        // Random stimulus
        for (int i = 0; i < 600; i++) begin
            cyc(4'($urandom_range(0, 15)), W'($urandom), W'($urandom));
        end
        while (busy && m_mul_left > 0) cyc(4'h0, 0, 0);
        check("sb_queue_empty", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound so a stuck run still reports
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
